// File: rtl/aes_subshift_serial.sv
// Column-serial AES SubBytes + ShiftRows: four shared S-boxes substitute one
// column per cycle, then the row-shifted state is held until downstream accepts.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv  = ginv(din);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// state | meaning
// IDLE  | ready for a new state word
// SUB   | substituting column col (4 cycles, columns 0..3)
// OUT   | presenting ShiftRows(work) until out_ready
module aes_subshift_serial (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);
    typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;

    state_t         state;
    state_t         state_nx;
    logic   [1:0]   col;
    logic   [127:0] work;
    logic           last_q;
    logic   [31:0]  col_bytes;
    logic   [31:0]  col_sub;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = SUB;
            SUB:     if (col == 2'd3) state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_last  = last_q;

    always_comb begin
        col_bytes = work[127:96];
        case (col)
            2'd0: col_bytes = work[127:96];
            2'd1: col_bytes = work[95:64];
            2'd2: col_bytes = work[63:32];
            2'd3: col_bytes = work[31:0];
            default: col_bytes = work[127:96];
        endcase
    end

    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (col_bytes[31-8*r -: 8]),
                .dout (col_sub[31-8*r -: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col    <= 2'd0;
            work   <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= in_state;
                        last_q <= in_last;
                        col    <= 2'd0;
                    end
                end
                SUB: begin
                    case (col)
                        2'd0: work[127:96] <= col_sub;
                        2'd1: work[95:64]  <= col_sub;
                        2'd2: work[63:32]  <= col_sub;
                        2'd3: work[31:0]   <= col_sub;
                        default: ;
                    endcase
                    col <= col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Row r of output column c comes from column (c+r) mod 4: pure wiring
    generate
        for (c = 0; c < 4; c++) begin : g_col
            for (r = 0; r < 4; r++) begin : g_row
                assign out_state[127-8*(r+4*c) -: 8] = work[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    endgenerate
endmodule
